// File: rtl/ramb4_s8_fifo_ctrl.sv
// Single-clock FIFO controller around a 512x8 dual-port block RAM.
// Port A is write-only, port B is read-only; read data arrives one cycle after an accepted read.
module ramb4_s8_fifo_ctrl #(
   parameter int unsigned ADDR_WIDTH    = 9,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned AFULL_THRESH  = 448,
   parameter int unsigned AEMPTY_THRESH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   output logic [ADDR_WIDTH-1:0] ram_addra_o,
   output logic [DATA_WIDTH-1:0] ram_dia_o,
   output logic                  ram_ena_o,
   output logic                  ram_wea_o,
   output logic [ADDR_WIDTH-1:0] ram_addrb_o,
   output logic                  ram_enb_o,
   input  logic [DATA_WIDTH-1:0] ram_dob_i
);

   localparam logic [ADDR_WIDTH:0] AfullCnt  = AFULL_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AemptyCnt = AEMPTY_THRESH[ADDR_WIDTH:0];

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  rd_valid_q, overflow_q, underflow_q;
   logic [DATA_WIDTH-1:0] rd_hold_q;
   logic                  full, empty, wr_acc, rd_acc;

   // Occupancy never exceeds the depth, so the count MSB alone marks full.
   assign full   = count_q[ADDR_WIDTH];
   assign empty  = (count_q == '0);
   assign wr_acc = wr_en_i & ~full & ~rst_i;
   assign rd_acc = rd_en_i & ~empty & ~rst_i;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_hold_q   <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_acc;
         overflow_q  <= wr_en_i & full;
         underflow_q <= rd_en_i & empty;
         if (rd_valid_q) rd_hold_q <= ram_dob_i;
      end
   end

   // Pass RAM output through while valid, otherwise show the last delivered byte.
   assign rd_data_o      = rd_valid_q ? ram_dob_i : rd_hold_q;
   assign rd_valid_o     = rd_valid_q;
   assign full_o         = full;
   assign empty_o        = empty;
   assign almost_full_o  = (count_q >= AfullCnt);
   assign almost_empty_o = (count_q <= AemptyCnt);
   assign count_o        = count_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;
   assign ram_addra_o    = wptr_q;
   assign ram_dia_o      = wr_data_i;
   assign ram_ena_o      = wr_acc;
   assign ram_wea_o      = wr_acc;
   assign ram_addrb_o    = rptr_q;
   assign ram_enb_o      = rd_acc;

endmodule

// File: tb/tb_ramb4_s8_fifo_ctrl.sv
// Bench for ramb4_s8_fifo_ctrl: behavioural RAM plus a queue-based FIFO reference model.
module tb_ramb4_s8_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [9:0] count;
   logic [8:0] ram_addra, ram_addrb;
   logic [7:0] ram_dia;
   logic [7:0] ram_dob = 8'h00;
   logic       ram_ena, ram_wea, ram_enb;

   ramb4_s8_fifo_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .wr_en_i       (wr_en),
      .wr_data_i     (wr_data),
      .rd_en_i       (rd_en),
      .rd_data_o     (rd_data),
      .rd_valid_o    (rd_valid),
      .full_o        (full),
      .empty_o       (empty),
      .almost_full_o (almost_full),
      .almost_empty_o(almost_empty),
      .count_o       (count),
      .overflow_o    (overflow),
      .underflow_o   (underflow),
      .ram_addra_o   (ram_addra),
      .ram_dia_o     (ram_dia),
      .ram_ena_o     (ram_ena),
      .ram_wea_o     (ram_wea),
      .ram_addrb_o   (ram_addrb),
      .ram_enb_o     (ram_enb),
      .ram_dob_i     (ram_dob)
   );

   always #5 clk = ~clk;

   // Behavioural RAMB4_S8_S8 with a same-address collision counter.
   logic [7:0] mem [512];
   int         collisions = 0;
   always @(posedge clk) begin
      if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
      if (ram_enb) ram_dob <= mem[ram_addrb];
      if (ram_ena && ram_enb && (ram_addra == ram_addrb)) collisions <= collisions + 1;
   end

   // Reference model state
   logic [7:0] mq[$];
   int         wr_total = 0;
   logic       exp_valid = 1'b0, exp_ovf = 1'b0, exp_unf = 1'b0;
   logic [7:0] exp_data = 8'h00;
   int         n_pass = 0, n_total = 0;

   task automatic model_reset();
      mq.delete();
      wr_total  = 0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
   endtask

   // Drive one cycle and advance the model; outputs are then sampled 1 time unit after the edge.
   task automatic cycle(input logic wr, input logic [7:0] d, input logic rd);
      bit f, e;
      wr_en = wr; wr_data = d; rd_en = rd;
      f = (mq.size() == 512);
      e = (mq.size() == 0);
      exp_ovf   = wr && f;
      exp_unf   = rd && e;
      exp_valid = rd && !e;
      if (exp_valid) exp_data = mq.pop_front();
      if (wr && !f) begin mq.push_back(d); wr_total++; end
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
      #2;
      n_total++; if ({ram_ena, ram_wea, ram_enb} !== 3'b000)
         $display("FAIL reset_ram_en got=%b want=000", {ram_ena, ram_wea, ram_enb}); else n_pass++;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      model_reset();
      n_total++; if (count !== 10'd0) $display("FAIL reset_count got=%0d want=0", count); else n_pass++;
      n_total++; if ({empty, almost_empty, full, almost_full} !== 4'b1100)
         $display("FAIL reset_flags got=%b want=1100", {empty, almost_empty, full, almost_full});
      else n_pass++;
      n_total++; if ({rd_valid, overflow, underflow} !== 3'b000)
         $display("FAIL reset_pulses got=%b want=000", {rd_valid, overflow, underflow}); else n_pass++;
      n_total++; if ({ram_addra, ram_addrb} !== 18'd0)
         $display("FAIL reset_ptrs got=%h/%h want=0/0", ram_addra, ram_addrb); else n_pass++;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b0);
      n_total++; if (count !== 10'd10) $display("FAIL basic_count got=%0d want=10", count); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 8'h00, 1'b1);
         n_total++; if (rd_valid !== 1'b1 || rd_data !== 8'(i))
            $display("FAIL basic_read%0d got=%b/%h want=1/%h", i, rd_valid, rd_data, 8'(i));
         else n_pass++;
      end
      cycle(1'b0, 8'h00, 1'b0);
      n_total++; if (rd_valid !== 1'b0 || rd_data !== 8'h09)
         $display("FAIL basic_hold got=%b/%h want=0/09", rd_valid, rd_data); else n_pass++;
      n_total++; if (empty !== 1'b1) $display("FAIL basic_empty got=%b want=1", empty); else n_pass++;
   endtask

   logic [7:0] first_byte;

   task automatic test_fill();
      for (int i = 0; i < 512; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if (i == 0) first_byte = b;
         cycle(1'b1, b, 1'b0);
         n_total++; if (almost_full !== (i + 1 >= 448))
            $display("FAIL fill_afull at write %0d got=%b want=%b", i + 1, almost_full, i + 1 >= 448);
         else n_pass++;
      end
      n_total++; if (full !== 1'b1 || count !== 10'd512)
         $display("FAIL fill_full got=%b/%0d want=1/512", full, count); else n_pass++;
      cycle(1'b1, 8'hEE, 1'b0);
      n_total++; if (overflow !== 1'b1 || count !== 10'd512)
         $display("FAIL fill_overflow got=%b/%0d want=1/512", overflow, count); else n_pass++;
      cycle(1'b0, 8'h00, 1'b0);
      n_total++; if (overflow !== 1'b0) $display("FAIL fill_ovf_pulse got=%b want=0", overflow);
      else n_pass++;
   endtask

   task automatic test_full_rw();
      cycle(1'b1, 8'h3C, 1'b1);
      n_total++; if (count !== 10'd511 || overflow !== 1'b1)
         $display("FAIL fullrw_count_ovf got=%0d/%b want=511/1", count, overflow); else n_pass++;
      n_total++; if (rd_valid !== 1'b1 || rd_data !== first_byte)
         $display("FAIL fullrw_data got=%b/%h want=1/%h", rd_valid, rd_data, first_byte);
      else n_pass++;
      while (mq.size() > 0) begin
         cycle(1'b0, 8'h00, 1'b1);
         n_total++; if (rd_data !== exp_data || almost_empty !== (mq.size() <= 16))
            $display("FAIL drain_data got=%h/%b want=%h/%b", rd_data, almost_empty, exp_data,
                     mq.size() <= 16);
         else n_pass++;
      end
      n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b want=1", empty); else n_pass++;
   endtask

   task automatic test_empty_rw();
      cycle(1'b1, 8'hA5, 1'b1);
      n_total++; if (underflow !== 1'b1 || count !== 10'd1 || rd_valid !== 1'b0)
         $display("FAIL emptyrw got=%b/%0d/%b want=1/1/0", underflow, count, rd_valid); else n_pass++;
      cycle(1'b0, 8'h00, 1'b1);
      n_total++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || underflow !== 1'b0)
         $display("FAIL emptyrw_read got=%b/%h/%b want=1/a5/0", rd_valid, rd_data, underflow);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 1000; i++) begin
         cycle(1'b1, 8'($urandom), 1'b1);
         n_total++; if (count !== 10'd5 || rd_valid !== 1'b1 || rd_data !== exp_data)
            $display("FAIL b2b cyc%0d got=%0d/%b/%h want=5/1/%h", i, count, rd_valid, rd_data, exp_data);
         else n_pass++;
      end
      n_total++; if (ram_addra !== 9'(wr_total % 512))
         $display("FAIL b2b_wrap got=%0d want=%0d", ram_addra, wr_total % 512); else n_pass++;
      n_total++; if (collisions !== 0) $display("FAIL b2b_collisions got=%0d want=0", collisions);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         int bias;
         bias = ((i / 600) % 2 == 0) ? 80 : 20;
         cycle($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) >= bias);
         n_total++; if (int'(count) !== mq.size() || full !== (mq.size() == 512) ||
                        empty !== (mq.size() == 0) || almost_full !== (mq.size() >= 448) ||
                        almost_empty !== (mq.size() <= 16))
            $display("FAIL rand_occ cyc%0d got=%0d/%b%b%b%b want=%0d", i, count, full, empty,
                     almost_full, almost_empty, mq.size());
         else n_pass++;
         n_total++; if (rd_valid !== exp_valid || overflow !== exp_ovf || underflow !== exp_unf ||
                        (exp_valid && rd_data !== exp_data))
            $display("FAIL rand_out cyc%0d got=%b%b%b/%h want=%b%b%b/%h", i, rd_valid, overflow,
                     underflow, rd_data, exp_valid, exp_ovf, exp_unf, exp_data);
         else n_pass++;
      end
      n_total++; if (collisions !== 0) $display("FAIL rand_collisions got=%0d want=0", collisions);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      while (mq.size() > 0) cycle(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 37; i++) cycle(1'b1, 8'($urandom), 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      n_total++; if (rd_valid !== 1'b1 || count !== 10'd36)
         $display("FAIL mid_pre got=%b/%0d want=1/36", rd_valid, count); else n_pass++;
      rd_en = 1'b1; wr_en = 1'b1;
      #1 rst = 1'b1;
      #1;
      n_total++; if (rd_valid !== 1'b0 || count !== 10'd0 || empty !== 1'b1)
         $display("FAIL mid_reset got=%b/%0d/%b want=0/0/1", rd_valid, count, empty); else n_pass++;
      n_total++; if (ram_enb !== 1'b0 || ram_ena !== 1'b0)
         $display("FAIL mid_ram_en got=%b%b want=00", ram_ena, ram_enb); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b1; wr_data = 8'h77;
      model_reset();
      #1;
      n_total++; if (ram_addra !== 9'd0 || ram_ena !== 1'b1)
         $display("FAIL mid_addr got=%0d/%b want=0/1", ram_addra, ram_ena); else n_pass++;
      @(negedge clk);
      cycle(1'b1, 8'h77, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      n_total++; if (rd_valid !== 1'b1 || rd_data !== 8'h77)
         $display("FAIL mid_readback got=%b/%h want=1/77", rd_valid, rd_data); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_full_rw();
      test_empty_rw();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
